// File: rtl/window_framer.sv
// Window framer: streams one N-sample frame from the filtered-sample RAM,
// applies a 16-bit Hann window and writes the result into the window RAM.
// Frames advance by HOP until the last legal base; then the block parks
// in EXHAUSTED until rewound.
module window_framer #(
  parameter int unsigned N       = 64,
  parameter int unsigned HOP     = 32,
  parameter int unsigned F_DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         rewind,
  output logic [$clog2(F_DEPTH)-1:0]   f_addr,
  input  logic signed [31:0]           f_dout,
  output logic                         w_we,
  output logic [$clog2(N)-1:0]         w_addr,
  output logic signed [31:0]           w_din,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(F_DEPTH)-1:0]   frame_base,
  output logic                         frame_last,
  output logic                         exhausted
);

  localparam int unsigned AW        = $clog2(F_DEPTH);
  localparam int unsigned IW        = $clog2(N);
  localparam int unsigned LAST_BASE = F_DEPTH - N;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE,
    S_EXH
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   f_addr_n;
  logic [AW-1:0]   base_n;
  logic            busy_n;
  logic            done_n;
  logic            exh_n;
  logic            last_n;

  // Pipeline: address stage -> (RAM data + ROM coef) stage -> write stage
  logic [15:0]     coef_q;
  logic            rd_v_q;
  logic [IW-1:0]   rd_idx_q;
  logic signed [48:0] prod_c;
  logic            unused_prod_bits;

  // Hann window ROM contents, folded around the centre tap (coef[64-i] = coef[i])
  function automatic logic [15:0] hann_coef(input logic [IW-1:0] i);
    logic [IW-1:0] k;
    logic [15:0]   c;
    k = i[IW-1] ? (IW'(0) - i) : i;
    case (k)
      6'd0:    c = 16'd0;
      6'd1:    c = 16'd158;
      6'd2:    c = 16'd630;
      6'd3:    c = 16'd1411;
      6'd4:    c = 16'd2494;
      6'd5:    c = 16'd3869;
      6'd6:    c = 16'd5522;
      6'd7:    c = 16'd7438;
      6'd8:    c = 16'd9597;
      6'd9:    c = 16'd11980;
      6'd10:   c = 16'd14563;
      6'd11:   c = 16'd17321;
      6'd12:   c = 16'd20228;
      6'd13:   c = 16'd23256;
      6'd14:   c = 16'd26375;
      6'd15:   c = 16'd29556;
      6'd16:   c = 16'd32768;
      6'd17:   c = 16'd35979;
      6'd18:   c = 16'd39160;
      6'd19:   c = 16'd42279;
      6'd20:   c = 16'd45307;
      6'd21:   c = 16'd48214;
      6'd22:   c = 16'd50972;
      6'd23:   c = 16'd53555;
      6'd24:   c = 16'd55938;
      6'd25:   c = 16'd58097;
      6'd26:   c = 16'd60013;
      6'd27:   c = 16'd61666;
      6'd28:   c = 16'd63041;
      6'd29:   c = 16'd64124;
      6'd30:   c = 16'd64905;
      6'd31:   c = 16'd65377;
      6'd32:   c = 16'd65535;
      default: c = 16'd0;
    endcase
    return c;
  endfunction

  // Next-state, address sequencing and registered-output precompute
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    f_addr_n = f_addr;
    base_n   = frame_base;
    case (state)
      S_IDLE: begin
        if (rewind) begin
          base_n = '0;
        end else if (start) begin
          state_n  = S_READ;
          f_addr_n = frame_base;
          cnt_n    = '0;
        end
      end
      S_READ: begin
        if (cnt == IW'(N - 1)) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n    = cnt + IW'(1);
          f_addr_n = f_addr + AW'(1);
        end
      end
      S_DRAIN: begin
        // Two cycles let the last sample clear the RAM and multiply stages
        if (cnt == IW'(1)) begin
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + IW'(1);
        end
      end
      S_DONE: begin
        if (frame_base >= AW'(LAST_BASE)) begin
          state_n = S_EXH;
        end else begin
          base_n  = frame_base + AW'(HOP);
          state_n = S_IDLE;
        end
      end
      S_EXH: begin
        if (rewind) begin
          base_n  = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_READ) || (state_n == S_DRAIN);
    done_n = (state_n == S_DONE);
    exh_n  = (state_n == S_EXH);
    last_n = (base_n == AW'(LAST_BASE));
  end

  // Control state and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      f_addr     <= '0;
      frame_base <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      exhausted  <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      f_addr     <= f_addr_n;
      frame_base <= base_n;
      busy       <= busy_n;
      done       <= done_n;
      exhausted  <= exh_n;
      frame_last <= last_n;
    end
  end

  // Q16.16 sample times unsigned Q0.16 coefficient; keep bits [47:16] (floor)
  assign prod_c           = f_dout * $signed({1'b0, coef_q});
  assign unused_prod_bits = ^{prod_c[48], prod_c[15:0]};

  // ROM read aligned with RAM latency, then product register into the write port
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_q   <= '0;
      rd_v_q   <= 1'b0;
      rd_idx_q <= '0;
      w_we     <= 1'b0;
      w_addr   <= '0;
      w_din    <= '0;
    end else begin
      coef_q   <= hann_coef(cnt);
      rd_v_q   <= (state == S_READ);
      rd_idx_q <= cnt;
      w_we     <= rd_v_q;
      if (rd_v_q) begin
        w_addr <= rd_idx_q;
        w_din  <= prod_c[47:16];
      end
    end
  end

endmodule

// File: tb/tb_window_framer.sv
// Directed bench for window_framer: frame timing, window values, frame
// stepping to exhaustion, ignored start/rewind, mid-frame reset, rewind.
module tb_window_framer;

  logic               clk;
  logic               rst;
  logic               start;
  logic               rewind;
  logic [9:0]         f_addr;
  logic signed [31:0] f_dout;
  logic               w_we;
  logic [5:0]         w_addr;
  logic signed [31:0] w_din;
  logic               busy;
  logic               done;
  logic [9:0]         frame_base;
  logic               frame_last;
  logic               exhausted;

  window_framer #(.N(64), .HOP(32), .F_DEPTH(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rewind     (rewind),
    .f_addr     (f_addr),
    .f_dout     (f_dout),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_din      (w_din),
    .busy       (busy),
    .done       (done),
    .frame_base (frame_base),
    .frame_last (frame_last),
    .exhausted  (exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample RAM model: one-cycle read latency, content chosen by dmode
  int dmode;
  always @(posedge clk) begin
    case (dmode)
      0:       f_dout <= 32'sh0001_0000;
      1:       f_dout <= 32'shFFFF_0000;
      default: f_dout <= {6'd0, f_addr, 16'd0};
    endcase
  end

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-run statistics
  logic [31:0] wmem [64];
  int wcount, first_we, last_we;
  int dcount, done_at;
  int busy_cnt, busy_first, busy_last;
  int seq_err, waddr_err;
  int max_faddr;

  // Pulse start at edge E0 and watch cycles 1..ncyc (sampled at negedge).
  // extra_start/rst_cyc/rew_cyc assert that input during the given cycle.
  task automatic run_frame(input int ncyc, input int extra_start, input int rst_cyc,
                           input int rew_cyc, input bit chk_seq);
    logic [9:0] base0;
    base0 = frame_base;
    wcount = 0; first_we = -1; last_we = -1;
    dcount = 0; done_at = -1;
    busy_cnt = 0; busy_first = -1; busy_last = -1;
    seq_err = 0; waddr_err = 0;
    for (int i = 0; i < 64; i++) wmem[i] = 32'hDEAD_BEEF;
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start  = (c == extra_start);
      rst    = (c == rst_cyc);
      rewind = (c == rew_cyc);
      if (w_we) begin
        wcount++;
        wmem[w_addr] = w_din;
        if (first_we < 0) first_we = c;
        last_we = c;
        if (int'(w_addr) != c - 3) waddr_err++;
      end
      if (done) begin
        dcount++;
        done_at = c;
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (int'(f_addr) > max_faddr) max_faddr = int'(f_addr);
      if (chk_seq && c <= 64 && (rst_cyc < 0 || c <= rst_cyc))
        if (f_addr !== base0 + 10'(c - 1)) seq_err++;
    end
    start = 1'b0; rst = 1'b0; rewind = 1'b0;
  endtask

  int total_done;
  int idle_busy;

  initial begin
    n_tests = 0; n_fail = 0; max_faddr = 0; dmode = 0;
    rst = 1'b1; start = 1'b0; rewind = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_frame_base", 32'(frame_base), 32'd0);
    check_eq("rst_f_addr",     32'(f_addr),     32'd0);
    check_eq("rst_w_we",       32'(w_we),       32'd0);
    check_eq("rst_w_addr",     32'(w_addr),     32'd0);
    check_eq("rst_w_din",      w_din,           32'd0);
    check_eq("rst_busy",       32'(busy),       32'd0);
    check_eq("rst_done",       32'(done),       32'd0);
    check_eq("rst_exhausted",  32'(exhausted),  32'd0);

    // Frame A: unity input -> window coefficients appear directly
    dmode = 0;
    run_frame(70, -1, -1, -1, 1'b1);
    check_eq("A_wcount",     32'(wcount),     32'd64);
    check_eq("A_first_we",   32'(first_we),   32'd3);
    check_eq("A_last_we",    32'(last_we),    32'd66);
    check_eq("A_waddr_seq",  32'(waddr_err),  32'd0);
    check_eq("A_faddr_seq",  32'(seq_err),    32'd0);
    check_eq("A_w0",         wmem[0],         32'h0000_0000);
    check_eq("A_w1",         wmem[1],         32'd158);
    check_eq("A_w16",        wmem[16],        32'd32768);
    check_eq("A_w32",        wmem[32],        32'h0000_FFFF);
    check_eq("A_w48",        wmem[48],        32'd32768);
    check_eq("A_w63",        wmem[63],        32'd158);
    check_eq("A_dcount",     32'(dcount),     32'd1);
    check_eq("A_done_at",    32'(done_at),    32'd67);
    check_eq("A_busy_cnt",   32'(busy_cnt),   32'd66);
    check_eq("A_busy_first", 32'(busy_first), 32'd1);
    check_eq("A_busy_last",  32'(busy_last),  32'd66);
    check_eq("A_frame_base", 32'(frame_base), 32'd32);

    // Frame B: -1.0 input; rewind during the frame is ignored
    dmode = 1;
    run_frame(70, -1, -1, 5, 1'b1);
    check_eq("B_w32",        wmem[32],        32'hFFFF_0001);
    check_eq("B_w0",         wmem[0],         32'h0000_0000);
    check_eq("B_wcount",     32'(wcount),     32'd64);
    check_eq("B_faddr_seq",  32'(seq_err),    32'd0);
    check_eq("B_frame_base", 32'(frame_base), 32'd64);

    // Frame C: address-valued data checks data/coef alignment; start at cycle 10 ignored
    dmode = 2;
    run_frame(75, 10, -1, -1, 1'b1);
    check_eq("C_w0",         wmem[0],         32'h0000_0000);
    check_eq("C_w1",         wmem[1],         32'd10270);
    check_eq("C_w16",        wmem[16],        32'h0028_0000);
    check_eq("C_w32",        wmem[32],        32'h005F_FFA0);
    check_eq("C_wcount",     32'(wcount),     32'd64);
    check_eq("C_dcount",     32'(dcount),     32'd1);
    check_eq("C_busy_cnt",   32'(busy_cnt),   32'd66);
    check_eq("C_frame_base", 32'(frame_base), 32'd96);

    // Frame D: reset during cycle 20 aborts the frame
    dmode = 0;
    run_frame(75, -1, 20, -1, 1'b1);
    check_eq("D_last_we",    32'(last_we),    32'd20);
    check_eq("D_wcount",     32'(wcount),     32'd18);
    check_eq("D_dcount",     32'(dcount),     32'd0);
    check_eq("D_busy_last",  32'(busy_last),  32'd20);
    check_eq("D_frame_base", 32'(frame_base), 32'd0);
    check_eq("D_faddr_seq",  32'(seq_err),    32'd0);

    // 31 back-to-back frames to exhaustion
    total_done = 0;
    max_faddr  = 0;
    for (int k = 0; k < 31; k++) begin
      if (k == 29) check_eq("X_last_before_30", 32'(frame_last), 32'd0);
      if (k == 30) begin
        check_eq("X_last_before_31", 32'(frame_last), 32'd1);
        check_eq("X_base_before_31", 32'(frame_base), 32'd960);
        check_eq("X_exh_before_31",  32'(exhausted),  32'd0);
      end
      run_frame(68, -1, -1, -1, 1'b1);
      total_done += dcount;
    end
    check_eq("X_total_done", 32'(total_done), 32'd31);
    check_eq("X_exhausted",  32'(exhausted),  32'd1);
    check_eq("X_base_hold",  32'(frame_base), 32'd960);
    check_eq("X_max_faddr",  32'(max_faddr),  32'd1023);
    check_eq("X_last_seq",   32'(seq_err),    32'd0);

    // 32nd start while exhausted: nothing happens
    run_frame(70, -1, -1, -1, 1'b0);
    check_eq("X32_dcount",   32'(dcount),     32'd0);
    check_eq("X32_wcount",   32'(wcount),     32'd0);
    check_eq("X32_busy",     32'(busy_cnt),   32'd0);
    check_eq("X32_exh",      32'(exhausted),  32'd1);

    // Rewind and start together in EXHAUSTED: rewind wins, no frame starts
    rewind = 1'b1; start = 1'b1;
    @(negedge clk);
    rewind = 1'b0; start = 1'b0;
    check_eq("R_frame_base", 32'(frame_base), 32'd0);
    check_eq("R_exhausted",  32'(exhausted),  32'd0);
    check_eq("R_frame_last", 32'(frame_last), 32'd0);
    idle_busy = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy || w_we || done) idle_busy++;
    end
    check_eq("R_no_frame",   32'(idle_busy),  32'd0);

    // Back in IDLE: a fresh start runs a frame from base 0
    dmode = 0;
    run_frame(70, -1, -1, -1, 1'b1);
    check_eq("R2_faddr_seq", 32'(seq_err),    32'd0);
    check_eq("R2_done_at",   32'(done_at),    32'd67);
    check_eq("R2_w32",       wmem[32],        32'h0000_FFFF);
    check_eq("R2_frame_base",32'(frame_base), 32'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
